// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs MULT/DIV families over a fixed busy latency.
// Optional MADD/MADDU/MSUB/MSUBU decode is enabled by defining MDU_MADD_EN.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  // Products
  logic signed [63:0] sa, sb;
  logic [63:0]        prod_s, prod_u;
  assign sa     = {{32{a[31]}}, a};
  assign sb     = {{32{b[31]}}, b};
  assign prod_s = sa * sb;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0
  logic [31:0] a_mag, b_mag, uq_mag, ur_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;
  assign b_zero = (b == 32'd0);
  assign a_mag  = a[31] ? (~a + 32'd1) : a;
  assign b_mag  = b[31] ? (~b + 32'd1) : b;
  assign uq_mag = b_zero ? 32'd0 : a_mag / b_mag;
  assign ur_mag = b_zero ? 32'd0 : a_mag % b_mag;
  assign q_s    = (a[31] ^ b[31]) ? (~uq_mag + 32'd1) : uq_mag;
  assign r_s    = a[31] ? (~ur_mag + 32'd1) : ur_mag;
  assign q_u    = b_zero ? 32'd0 : a / b;
  assign r_u    = b_zero ? 32'd0 : a % b;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  // Next-state and datapath decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {res_hi_d, res_lo_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_MULTU: begin
              {res_hi_d, res_lo_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_DIV: begin
              res_lo_d = b_zero ? lo_q : q_s;
              res_hi_d = b_zero ? hi_q : r_s;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = BUSY;
            end
            OP_DIVU: begin
              res_lo_d = b_zero ? lo_q : q_u;
              res_hi_d = b_zero ? hi_q : r_u;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {res_hi_d, res_lo_d} = acc + prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_MADDU: begin
              {res_hi_d, res_lo_d} = acc + prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_MSUB: begin
              {res_hi_d, res_lo_d} = acc - prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_MSUBU: begin
              {res_hi_d, res_lo_d} = acc - prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core, instantiated in the E stage beside the ALU. Owns architectural HI/LO and runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, exposing `busy` so the hazard unit can stall later HI/LO users and new MD commands in D. MTHI/MTLO write in one cycle; MFHI/MFLO read `hi`/`lo` combinationally.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `start`  in  1  E-stage instruction carries an MD command this cycle.
- `md_op`  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 NOP.
- `a`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `b`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  multi-cycle op in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States: IDLE, BUSY. Down-counter `cnt`, width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE, `start`=1:
  - MULT/MULTU/(MADD family): 64-bit result latched into internal `res_hi/res_lo`; `cnt`<=MULT_CYCLES; go BUSY.
  - DIV/DIVU: quotient→`res_lo`, remainder→`res_hi`; `cnt`<=DIV_CYCLES; go BUSY.
  - MTHI: `hi`<=`a` at this edge; stay IDLE. MTLO: `lo`<=`a`; stay IDLE.
  - NOP/undefined: no effect.
- BUSY: `cnt` decrements each edge; at the edge where `cnt`==1, `hi`<=`res_hi`, `lo`<=`res_lo`, go IDLE.
- `start` while BUSY ignored (operands, op dropped); the hazard unit guarantees this never happens in a correct core. Bench checks the drop.
- Arithmetic:
  - MULT signed 32×32→64; MULTU unsigned.
  - DIV signed: quotient truncates toward zero, remainder takes sign of dividend. 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - DIVU unsigned.
  - Divisor 0 (DIV/DIVU): full DIV_CYCLES busy, `hi`/`lo` unchanged at completion.
  - MADD/MADDU: {hi,lo} + product (signed/unsigned product), mod 2^64; MSUB/MSUBU: {hi,lo} − product. Accumulator base is `hi`/`lo` at the start edge.
- `reset`: `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE. Reset mid-operation aborts; no HI/LO write. Reset with `start` same edge: reset wins.

## Timing
- `busy` is registered: `state==BUSY`; never combinational from `start`. Hazard unit forms stall from `start | busy`.
- Start sampled at edge E0: `busy`=1 for the MULT_CYCLES (or DIV_CYCLES) cycles after E0; new `hi`/`lo` visible and `busy`=0 in the same cycle, i.e. after edge E0+MULT_CYCLES.
- Back-to-back: new `start` accepted in the first cycle with `busy`=0.
- MTHI/MTLO: value visible the cycle after the start edge; `busy` stays 0.
- `hi`/`lo` hold old values throughout BUSY.

## Configuration
- `MDU_MADD_EN` defined: md_op 7–10 decoded as MADD/MADDU/MSUB/MSUBU, MULT_CYCLES latency.
- Undefined: md_op 7–10 treated as NOP (no busy, no write); accumulator adder logic absent.

## Test plan
- Reset: hold `reset`=1 two cycles → `hi`=`lo`=0, `busy`=0; then MTHI a=0x12345678, MTLO a=0x9ABCDEF0 → next cycle `hi`=0x12345678, `lo`=0x9ABCDEF0, `busy` never 1.
- MULT a=0xFFFFFFFF (−1), b=2 → `busy`=1 exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7,b=0 → 10 busy cycles, hi/lo unchanged.
- Overflow/abort: DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; separate DIV with `reset` pulsed at busy cycle 4 → busy=0, hi=lo=0, no later write.
- Ignored start: MULT 3×4 then `start` MTHI a=0xDEAD during busy cycle 2 → final hi=0, lo=12; `hi` never 0xDEAD.
- `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, MADDU a=1,b=1 → hi=1, lo=0; without macro same stimulus → no busy, hi/lo unchanged.
